// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational CSR read, write-back commit, trap/mret
// state updates, 64-bit cycle/instret counters and interrupt-pending detection.
module csr_file #(
   parameter logic [31:0] HART_ID  = 32'd0,
   parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] csr_addr,
   output logic [31:0] csr_rd_data,
   input  logic        csr_wr_en,
   input  logic [31:0] csr_wr_data,
   output logic        csr_illegal,
   input  logic        instret_inc,
   input  logic        trap_valid,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_tval,
   input  logic        mret,
   input  logic        mtip,
   input  logic        meip,
   output logic [31:0] trap_vector,
   output logic [31:0] epc,
   output logic        irq_pending
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CLEN = 64;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MISA      = 12'h301;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   localparam logic [XLEN-1:0] ALIGN4_MASK = 32'hFFFF_FFFC;

   logic            mstatus_mie_q, mstatus_mpie_q;
   logic            mie_mtie_q, mie_meie_q;
   logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [CLEN-1:0] mcycle_q, minstret_q;
   logic [CLEN-1:0] mcycle_nx, minstret_nx;

   logic            addr_impl, addr_ro;
   logic            wr_ok;

   // Read mux and address classification
   always_comb begin
      csr_rd_data = '0;
      addr_impl   = 1'b1;
      addr_ro     = 1'b0;
      case (csr_addr)
         ADDR_MSTATUS:   csr_rd_data = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
         ADDR_MISA:      begin csr_rd_data = MISA_VAL; addr_ro = 1'b1; end
         ADDR_MIE:       csr_rd_data = {20'b0, mie_meie_q, 3'b0, mie_mtie_q, 7'b0};
         ADDR_MTVEC:     csr_rd_data = mtvec_q;
         ADDR_MSCRATCH:  csr_rd_data = mscratch_q;
         ADDR_MEPC:      csr_rd_data = mepc_q;
         ADDR_MCAUSE:    csr_rd_data = mcause_q;
         ADDR_MTVAL:     csr_rd_data = mtval_q;
         ADDR_MIP:       begin csr_rd_data = {20'b0, meip, 3'b0, mtip, 7'b0}; addr_ro = 1'b1; end
         ADDR_MCYCLE:    csr_rd_data = mcycle_q[31:0];
         ADDR_MCYCLEH:   csr_rd_data = mcycle_q[63:32];
         ADDR_MINSTRET:  csr_rd_data = minstret_q[31:0];
         ADDR_MINSTRETH: csr_rd_data = minstret_q[63:32];
         ADDR_CYCLE:     begin csr_rd_data = mcycle_q[31:0];    addr_ro = 1'b1; end
         ADDR_CYCLEH:    begin csr_rd_data = mcycle_q[63:32];   addr_ro = 1'b1; end
         ADDR_INSTRET:   begin csr_rd_data = minstret_q[31:0];  addr_ro = 1'b1; end
         ADDR_INSTRETH:  begin csr_rd_data = minstret_q[63:32]; addr_ro = 1'b1; end
         ADDR_MHARTID:   begin csr_rd_data = HART_ID; addr_ro = 1'b1; end
         default:        addr_impl = 1'b0;
      endcase
   end

   assign csr_illegal = ~addr_impl | (csr_wr_en & addr_ro);

   // Software writes lose to trap entry and mret in the same cycle
   assign wr_ok = csr_wr_en & addr_impl & ~addr_ro & ~trap_valid & ~mret;

   // A half-write freezes the other half: no increment, no carry that cycle
   always_comb begin
      mcycle_nx   = mcycle_q + CLEN'(1);
      minstret_nx = minstret_q + CLEN'(instret_inc);
      if (wr_ok) begin
         case (csr_addr)
            ADDR_MCYCLE:    mcycle_nx   = {mcycle_q[63:32], csr_wr_data};
            ADDR_MCYCLEH:   mcycle_nx   = {csr_wr_data, mcycle_q[31:0]};
            ADDR_MINSTRET:  minstret_nx = {minstret_q[63:32], csr_wr_data};
            ADDR_MINSTRETH: minstret_nx = {csr_wr_data, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_q        <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mcycle_q   <= mcycle_nx;
         minstret_q <= minstret_nx;
         if (trap_valid) begin
            mepc_q         <= trap_pc & ALIGN4_MASK;
            mcause_q       <= trap_cause;
            mtval_q        <= trap_tval;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
         end else if (mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end else if (wr_ok) begin
            case (csr_addr)
               ADDR_MSTATUS: begin
                  mstatus_mie_q  <= csr_wr_data[3];
                  mstatus_mpie_q <= csr_wr_data[7];
               end
               ADDR_MIE: begin
                  mie_mtie_q <= csr_wr_data[7];
                  mie_meie_q <= csr_wr_data[11];
               end
               ADDR_MTVEC:    mtvec_q    <= csr_wr_data & ALIGN4_MASK;
               ADDR_MSCRATCH: mscratch_q <= csr_wr_data;
               ADDR_MEPC:     mepc_q     <= csr_wr_data & ALIGN4_MASK;
               ADDR_MCAUSE:   mcause_q   <= csr_wr_data;
               ADDR_MTVAL:    mtval_q    <= csr_wr_data;
               default: ;
            endcase
         end
      end
   end

   assign trap_vector = mtvec_q;
   assign epc         = mepc_q;
   assign irq_pending = mstatus_mie_q & ((mie_mtie_q & mtip) | (mie_meie_q & meip));

endmodule

// File: tb/tb_csr_file.sv
// Randomized scoreboard bench for csr_file against a behavioural CSR model,
// preceded by directed sequences for reset, masking, trap/mret, counters and interrupts.
module tb_csr_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] csr_addr;
   logic [31:0] csr_rd_data;
   logic        csr_wr_en;
   logic [31:0] csr_wr_data;
   logic        csr_illegal;
   logic        instret_inc;
   logic        trap_valid;
   logic [31:0] trap_cause, trap_pc, trap_tval;
   logic        mret, mtip, meip;
   logic [31:0] trap_vector, epc;
   logic        irq_pending;

   csr_file dut (
      .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_rd_data(csr_rd_data),
      .csr_wr_en(csr_wr_en), .csr_wr_data(csr_wr_data), .csr_illegal(csr_illegal),
      .instret_inc(instret_inc), .trap_valid(trap_valid), .trap_cause(trap_cause),
      .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .mtip(mtip), .meip(meip),
      .trap_vector(trap_vector), .epc(epc), .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        ill;
      logic        irq;
      logic [31:0] tv;
      logic [31:0] epc;
      bit          k_en;
      logic [31:0] k_val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference state, in architectural terms
   bit              m_ok = 0;
   bit              m_mie, m_mpie;
   logic [31:0]     m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   longint unsigned m_cyc, m_inst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h (addr 0x%03h)", name, $time, act, exp, csr_addr);
      end
   endtask

   function automatic void ref_read(input logic [11:0] a, input logic tip, input logic eip,
                                    output logic [31:0] v, output bit impl, output bit ro);
      impl = 1; ro = 0; v = 32'h0;
      case (a)
         12'h300: v = 32'h0000_1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
         12'h301: begin v = 32'h4000_0100; ro = 1; end
         12'h304: v = m_mie_reg;
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'h343: v = m_mtval;
         12'h344: begin v = (tip ? 32'h80 : 32'h0) | (eip ? 32'h800 : 32'h0); ro = 1; end
         12'hB00: v = m_cyc[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB02: v = m_inst[31:0];
         12'hB82: v = m_inst[63:32];
         12'hC00: begin v = m_cyc[31:0];   ro = 1; end
         12'hC80: begin v = m_cyc[63:32];  ro = 1; end
         12'hC02: begin v = m_inst[31:0];  ro = 1; end
         12'hC82: begin v = m_inst[63:32]; ro = 1; end
         12'hF14: begin v = 32'h0; ro = 1; end
         default: impl = 0;
      endcase
   endfunction

   task automatic model_edge();
      logic [31:0]     v;
      bit              impl, ro;
      longint unsigned nc, ni;
      if (!rst_n) begin
         m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0;
         m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_inst = 0;
         m_ok = 1;
         return;
      end
      nc = m_cyc + 1;
      ni = m_inst + (instret_inc ? 1 : 0);
      ref_read(csr_addr, mtip, meip, v, impl, ro);
      if (trap_valid) begin
         m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
         m_mpie = m_mie; m_mie = 0;
      end else if (mret) begin
         m_mie = m_mpie; m_mpie = 1;
      end else if (csr_wr_en && impl && !ro) begin
         case (csr_addr)
            12'h300: begin m_mie = csr_wr_data[3]; m_mpie = csr_wr_data[7]; end
            12'h304: m_mie_reg = csr_wr_data & 32'h880;
            12'h305: m_mtvec = csr_wr_data & ~32'h3;
            12'h340: m_mscratch = csr_wr_data;
            12'h341: m_mepc = csr_wr_data & ~32'h3;
            12'h342: m_mcause = csr_wr_data;
            12'h343: m_mtval = csr_wr_data;
            12'hB00: nc = {m_cyc[63:32], csr_wr_data};
            12'hB80: nc = {csr_wr_data, m_cyc[31:0]};
            12'hB02: ni = {m_inst[63:32], csr_wr_data};
            12'hB82: ni = {csr_wr_data, m_inst[31:0]};
            default: ;
         endcase
      end
      m_cyc = nc;
      m_inst = ni;
   endtask

   // One cycle: queue the expected outputs for the current inputs, then advance the model
   task automatic step_k(input bit k_en, input logic [31:0] k_val);
      exp_t e;
      bit   impl, ro;
      if (m_ok) begin
         ref_read(csr_addr, mtip, meip, e.rd, impl, ro);
         e.ill   = !impl || (csr_wr_en && ro);
         e.irq   = m_mie && ((m_mie_reg[7] && mtip) || (m_mie_reg[11] && meip));
         e.tv    = m_mtvec;
         e.epc   = m_mepc;
         e.k_en  = k_en;
         e.k_val = k_val;
         sb.push_back(e);
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      step_k(0, 32'h0);
   endtask

   task automatic idle();
      csr_wr_en = 0; csr_wr_data = 0; instret_inc = 0; trap_valid = 0;
      trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      idle();
      csr_addr = a; csr_wr_en = 1; csr_wr_data = d;
      step();
      idle();
   endtask

   task automatic rd_k(input logic [11:0] a, input logic [31:0] k);
      idle();
      csr_addr = a;
      step_k(1, k);
   endtask

   // Monitor: compare every queued expectation against the settled outputs
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("rd_data", csr_rd_data, e.rd);
         chk("illegal", 32'(csr_illegal), 32'(e.ill));
         chk("irq_pending", 32'(irq_pending), 32'(e.irq));
         chk("trap_vector", trap_vector, e.tv);
         chk("epc", epc, e.epc);
         if (e.k_en) chk("directed_rd", csr_rd_data, e.k_val);
      end
   end

   logic [11:0] addr_list [22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                   12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                                   12'h302, 12'h7C0, 12'hB01, 12'hF11};

   initial begin
      idle();
      mtip = 0; meip = 0; csr_addr = 12'h300;
      rst_n = 0;
      step(); step();
      rst_n = 1;

      // Reset release and counter start
      rd_k(12'hB00, 32'd0);
      rd_k(12'h300, 32'h1800);
      rd_k(12'h341, 32'd0);
      rd_k(12'hB00, 32'd3);
      rd_k(12'hB00, 32'd4);
      rd_k(12'hB00, 32'd5);

      // Masking and read-only
      wr(12'h305, 32'h8000_0103);
      rd_k(12'h305, 32'h8000_0100);
      wr(12'h304, 32'hFFFF_FFFF);
      rd_k(12'h304, 32'h0000_0880);
      wr(12'h301, 32'h0);
      rd_k(12'h301, 32'h4000_0100);

      // Trap then mret
      wr(12'h300, 32'h8);
      idle();
      csr_addr = 12'h342; trap_valid = 1; trap_pc = 32'h0000_1237; trap_cause = 32'h8000_000B;
      step();
      rd_k(12'h342, 32'h8000_000B);
      rd_k(12'h341, 32'h0000_1234);
      rd_k(12'h300, 32'h1880);
      idle(); mret = 1; step();
      rd_k(12'h300, 32'h1888);

      // Counter wrap and write-vs-increment
      wr(12'hB80, 32'hFFFF_FFFF);
      wr(12'hB00, 32'hFFFF_FFFE);
      rd_k(12'hB00, 32'hFFFF_FFFE);
      rd_k(12'hB00, 32'hFFFF_FFFF);
      rd_k(12'hB00, 32'h0);
      rd_k(12'hB80, 32'h0);
      idle(); csr_addr = 12'hB02; csr_wr_en = 1; csr_wr_data = 32'h1234_5678; instret_inc = 1;
      step();
      rd_k(12'hB02, 32'h1234_5678);

      // Same-cycle priority
      wr(12'h300, 32'h8);
      idle();
      csr_addr = 12'h341; trap_valid = 1; mret = 1; csr_wr_en = 1; csr_wr_data = 32'h40;
      trap_pc = 32'h0000_2003;
      step();
      rd_k(12'h341, 32'h0000_2000);
      rd_k(12'h300, 32'h1880);

      // Interrupt pending
      wr(12'h300, 32'h8);
      wr(12'h304, 32'h80);
      mtip = 1;
      rd_k(12'h344, 32'h80);
      wr(12'h300, 32'h0);
      rd_k(12'h300, 32'h1800);
      wr(12'h300, 32'h8);
      mtip = 0; meip = 1;
      rd_k(12'h344, 32'h800);
      meip = 0;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int unsigned idx;
         idle();
         idx = $urandom_range(0, 22);
         csr_addr    = (idx == 22) ? 12'($urandom) : addr_list[idx];
         csr_wr_en   = ($urandom_range(0, 2) == 0);
         csr_wr_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
         instret_inc = 1'($urandom);
         trap_valid  = ($urandom_range(0, 15) == 0);
         trap_cause  = $urandom;
         trap_pc     = $urandom;
         trap_tval   = $urandom;
         mret        = ($urandom_range(0, 11) == 0);
         mtip        = 1'($urandom);
         meip        = 1'($urandom);
         rst_n       = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_n = 1;
      idle();
      @(negedge clk);
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control and status register file for the pipeline's CSR path. It supplies the current CSR value (`csr_rd_data`) that the CSR ALU combines with the register or immediate operand, and it commits the ALU result on write-back. It also owns trap entry and `mret` state updates, the 64-bit `mcycle`/`minstret` counters, and interrupt-pending detection toward the pipeline controller.

## Interface
- `HART_ID`, 0: value returned by `mhartid` (0xF14)
- `MISA_VAL`, 32'h4000_0100: value returned by `misa` (0x301), read-only
- `clk` input 1: single clock; all state updates on the rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `csr_addr` input 12: CSR address for both read and write
- `csr_rd_data` output 32: combinational read of `csr_addr`
- `csr_wr_en` input 1: commit `csr_wr_data` to `csr_addr` this edge
- `csr_wr_data` input 32: CSR ALU result
- `csr_illegal` output 1: combinational flag for an unimplemented address, or for `csr_wr_en` to a read-only address
- `instret_inc` input 1: one instruction retired this cycle
- `trap_valid` input 1: take a trap this edge
- `trap_cause` input 32: value for `mcause`
- `trap_pc` input 32: faulting PC, written to `mepc`
- `trap_tval` input 32: value for `mtval`
- `mret` input 1: return from trap this edge
- `mtip`, `meip` input 1 each: timer and external interrupt lines, level
- `trap_vector` output 32: `mtvec`, registered (direct mode)
- `epc` output 32: `mepc`, registered
- `irq_pending` output 1: combinational, `mstatus.MIE & ((mie[7]&mtip) | (mie[11]&meip))`

## Operation
- **Implemented CSRs:**
  - `mstatus` 0x300: MIE bit 3, MPIE bit 7, MPP[12:11] hardwired to 2'b11; all other bits read 0.
  - `misa` 0x301: read-only.
  - `mie` 0x304: only bits 7 and 11 are writable.
  - `mtvec` 0x305: bits [1:0] forced to 0.
  - `mscratch` 0x340.
  - `mepc` 0x341: bits [1:0] forced to 0.
  - `mcause` 0x342.
  - `mtval` 0x343.
  - `mip` 0x344: read-only; bit 7 = `mtip`, bit 11 = `meip`.
  - `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82: writable.
  - `cycle`/`cycleh`/`instret`/`instreth` 0xC00/0xC80/0xC02/0xC82: read-only shadows.
  - `mhartid` 0xF14: read-only.
- **Unimplemented addresses:** read 0 and assert `csr_illegal`. Writes to them, or to read-only CSRs, are dropped and assert `csr_illegal` while `csr_wr_en`=1.
- **Reset values (`rst_n`=0 at an edge):**
  - `mstatus` = 0x0000_1800.
  - `mie`, `mtvec`, `mscratch`, `mepc`, `mcause`, `mtval` = 0.
  - Both 64-bit counters = 0.
  - Outputs after reset: `trap_vector`=0, `epc`=0, `irq_pending`=0.
- **Counters:**
  - `mcycle` increments by 1 every non-reset cycle.
  - `minstret` increments when `instret_inc`=1.
  - Both wrap 0xFFFF_FFFF_FFFF_FFFF → 0.
  - A write to one half replaces that half. The other half holds its value that cycle, with no increment and no carry.
- **Trap entry (`trap_valid`):**
  - `mepc` ← `trap_pc` & ~3; `mcause` ← `trap_cause`; `mtval` ← `trap_tval`.
  - MPIE ← MIE; MIE ← 0.
- **`mret`:** MIE ← MPIE; MPIE ← 1.
- **Same-cycle priority:** `trap_valid` > `mret` > `csr_wr_en`.
  - When a higher-priority event fires, the lower ones are ignored that cycle for all registers they would touch.
  - Counter increments proceed regardless.

## Timing
- Reads are combinational from registered state, with zero latency. A read returns the pre-edge value, so `mcycle` read in cycle N equals N cycles since reset release.
- Writes, trap, and `mret` take effect at the edge. They are visible on `csr_rd_data`, `trap_vector`, `epc`, and `irq_pending` in the next cycle.
- No read-during-write bypass. The CSR instruction reads before it writes, and the pipeline serializes CSR accesses.
- Reset mid-trap or mid-write: reset wins and all state returns to its reset value.
- `irq_pending` follows `mtip`/`meip` combinationally, and follows MIE/`mie` one cycle after they are written.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles, then release → `mstatus` reads 0x1800, `mepc`=0, `mcycle`=0 in the first cycle after release, and `mcycle`=5 after five further cycles.
- **Read/write masking:**
  - Write `mtvec`=0x8000_0103 → reads 0x8000_0100.
  - Write `mie`=0xFFFF_FFFF → reads 0x0000_0880.
  - Write to `misa` → `csr_illegal`=1 and the value is unchanged.
- **Trap then `mret`:**
  - Setup: MIE=1. Apply `trap_valid`, `trap_pc`=0x0000_1237, `trap_cause`=0x8000_000B.
  - After the trap: `epc`=0x1234, `mcause`=0x8000_000B, `mstatus`=0x1880.
  - Then `mret` → `mstatus`=0x1888.
- **Counter wrap and write:**
  - Write `mcycleh`=0xFFFF_FFFF, then `mcycle`=0xFFFF_FFFE → two cycles later the 64-bit value is 0.
  - `minstret` write with `instret_inc`=1 in the same cycle → the written value holds.
- **Priority:** `trap_valid`, `mret`, and `csr_wr_en` to `mepc`=0x40 all in the same cycle → `mepc`=`trap_pc`&~3 and MIE=0.
- **Interrupt:** MIE=1, `mie`=0x80, `mtip`=1 → `irq_pending`=1. Clear MIE → `irq_pending`=0 on the next cycle. With `meip`=1 and `mie[11]`=0 → `irq_pending`=0.
